// File: rtl/maria_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maria_pkg
//  Description : Shared constants for the Maria CPU clock generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package maria_pkg;

  // Master ticks per CPU cycle for fast and slow accesses
  localparam int CPU_FAST_TICKS = 4;
  localparam int CPU_SLOW_TICKS = 6;

  // Width of the tick index inside a CPU cycle
  localparam int TCNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/cpu_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_phase_counter
//  Description : Counts Maria master ticks into 6502 bus cycles, producing the
//                phase-2 level, the end-of-cycle strobe and the latched length.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_phase_counter
  import maria_pkg::*;
#(
  parameter int FAST_TICKS = CPU_FAST_TICKS,
  parameter int SLOW_TICKS = CPU_SLOW_TICKS
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_hold,
  input  logic i_sel_slow,
  output logic o_pclk0,
  output logic o_pclkp,
  output logic o_slow,
  output logic o_wrap
);

  localparam logic [TCNT_W-1:0] C_FAST = TCNT_W'(FAST_TICKS);
  localparam logic [TCNT_W-1:0] C_SLOW = TCNT_W'(SLOW_TICKS);

  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] r_len;
  logic              r_slow;
  logic              r_pclk0;
  logic              r_pclkp;

  logic [TCNT_W-1:0] w_len_eff;
  logic [TCNT_W-1:0] w_last;
  logic [TCNT_W-1:0] w_half;
  logic [TCNT_W-1:0] w_tnext;
  logic              w_adv;
  logic              w_at_last;

  // Tick 0 uses the freshly sampled length so the half/last points of the
  // new cycle are right even before r_len has been updated.
  assign w_len_eff = (r_tcnt == '0) ? (i_sel_slow ? C_SLOW : C_FAST) : r_len;
  assign w_last    = w_len_eff - TCNT_W'(1);
  assign w_half    = w_len_eff >> 1;
  assign w_tnext   = r_tcnt + TCNT_W'(1);
  assign w_adv     = i_tick & ~i_hold;
  assign w_at_last = (r_tcnt == w_last);
  assign o_wrap    = w_adv & w_at_last;

  // Tick counter, length latch and phase outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt  <= '0;
      r_len   <= C_FAST;
      r_slow  <= 1'b0;
      r_pclk0 <= 1'b0;
      r_pclkp <= 1'b0;
    end else begin
      r_pclkp <= 1'b0;
      if (w_adv) begin
        if (r_tcnt == '0) begin
          r_len  <= w_len_eff;
          r_slow <= i_sel_slow;
        end
        if (w_at_last) begin
          r_tcnt  <= '0;
          r_pclk0 <= 1'b0;
          r_pclkp <= 1'b1;
        end else begin
          r_tcnt <= w_tnext;
          if (w_tnext == w_half) begin
            r_pclk0 <= 1'b1;
          end
        end
      end
    end
  end

  assign o_pclk0 = r_pclk0;
  assign o_pclkp = r_pclkp;
  assign o_slow  = r_slow;

endmodule
`default_nettype wire

// File: rtl/maria_cpu_clock.sv
`default_nettype none
// ============================================================================
//  Module      : maria_cpu_clock
//  Description : 6502 bus-cycle phase generator for Maria: fast/slow cycles,
//                WSYNC stall on RDY and DMA suspension at cycle boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module maria_cpu_clock
  import maria_pkg::*;
#(
  parameter int FAST_TICKS = CPU_FAST_TICKS,
  parameter int SLOW_TICKS = CPU_SLOW_TICKS
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic mclk0,
  input  logic sel_slow_clock,
  input  logic wsync,
  input  logic line_end,
  input  logic dma_req,
  output logic pclk0,
  output logic pclkp,
  output logic rdy,
  output logic dma_grant,
  output logic slow_cycle
);

  logic r_wsync_pend;
  logic r_granted;
  logic r_rdy;
  logic w_wrap;
  logic w_pend_nxt;

  // wsync beats a coincident line_end so the stall carries to the next line
  assign w_pend_nxt = wsync | (r_wsync_pend & ~line_end);

  cpu_phase_counter #(
    .FAST_TICKS (FAST_TICKS),
    .SLOW_TICKS (SLOW_TICKS)
  ) u_phase (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .i_tick     (mclk0),
    .i_hold     (r_granted),
    .i_sel_slow (sel_slow_clock),
    .o_pclk0    (pclk0),
    .o_pclkp    (pclkp),
    .o_slow     (slow_cycle),
    .o_wrap     (w_wrap)
  );

  // WSYNC pending flag, updated even while the bus is granted
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wsync_pend <= 1'b0;
    end else begin
      r_wsync_pend <= w_pend_nxt;
    end
  end

  // RDY and DMA grant change only at cycle boundaries or on grant release
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_granted <= 1'b0;
      r_rdy     <= 1'b1;
    end else if (r_granted) begin
      if (!dma_req) begin
        r_granted <= 1'b0;
        r_rdy     <= ~w_pend_nxt;
      end
    end else if (w_wrap) begin
      r_rdy <= ~w_pend_nxt;
      if (dma_req) begin
        r_granted <= 1'b1;
      end
    end
  end

  assign rdy       = r_rdy;
  assign dma_grant = r_granted;

endmodule
`default_nettype wire
